// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch block: widths, FSM states and
// the byte0 bit that selects instruction length.
package ifetch_pkg;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int LEN_BIT = 7;

    typedef enum logic [2:0] {
        ISSUE0,
        CAP0,
        ISSUE1,
        CAP1,
        HOLD
    } state_e;

    // Set byte0[LEN_BIT] marks a one-byte instruction.
    function automatic logic is_short(input logic [DATA_W-1:0] b);
        return b[LEN_BIT];
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Fetch program counter: load has priority over increment, and the
// increment wraps modulo 2^ADDR_W.
module ifetch_pc
    import ifetch_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_new_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = pc_new_i;
        else if (inc_i)
            pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads 1- or 2-byte instructions from a
// registered byte memory and holds each until accepted. Optional stall
// counter output is enabled by defining IFETCH_STALL_CNT_EN.
module instr_fetch
    import ifetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic              memRead,
    output logic [ADDR_W-1:0] addressMem,
    input  logic [DATA_W-1:0] memOut,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              is_long,
    output logic [ADDR_W-1:0] instr_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] byte0_q, byte0_d;
    logic [DATA_W-1:0] byte1_q, byte1_d;
    logic              long_q, long_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    ifetch_pc u_pc (
        .clk_i    (clock),
        .rst_i    (reset),
        .load_i   (pc_load),
        .pc_new_i (pc_new),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    always_comb begin
        state_d    = state_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
        long_d     = long_q;
        instr_pc_d = instr_pc_q;
        pc_inc     = 1'b0;
        case (state_q)
            ISSUE0: state_d = CAP0;
            CAP0: begin
                byte0_d    = memOut;
                byte1_d    = '0;
                long_d     = ~is_short(memOut);
                instr_pc_d = pc;
                pc_inc     = 1'b1;
                state_d    = is_short(memOut) ? HOLD : ISSUE1;
            end
            ISSUE1: state_d = CAP1;
            CAP1: begin
                byte1_d = memOut;
                pc_inc  = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (instr_ready) state_d = ISSUE0;
            default: state_d = ISSUE0;
        endcase
        // A redirect abandons any partial instruction; a read still in
        // flight lands while we sit in ISSUE0 and is never captured.
        if (pc_load) begin
            state_d    = ISSUE0;
            byte0_d    = '0;
            byte1_d    = '0;
            long_d     = 1'b0;
            instr_pc_d = instr_pc_q;
            pc_inc     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ISSUE0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            long_q     <= 1'b0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
            long_q     <= long_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign memRead     = ~reset & ((state_q == ISSUE0) | (state_q == ISSUE1));
    assign addressMem  = pc;
    assign instr_valid = ~reset & (state_q == HOLD);
    assign opcode      = byte0_q[7:5];
    assign operand     = long_q ? {byte0_q[4:0], byte1_q} : {8'h00, byte0_q[4:0]};
    assign is_long     = long_q;
    assign instr_pc    = instr_pc_q;

`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset)
            stall_q <= '0;
        else if (instr_valid && !instr_ready && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a registered byte-memory model plus a
// scoreboard of expected instructions, compared as each one becomes valid.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        memRead;
    logic [12:0] addressMem;
    logic [7:0]  memOut = 8'h00;
    logic        pc_load = 1'b0;
    logic [12:0] pc_new = 13'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [2:0]  opcode;
    logic [12:0] operand;
    logic        is_long;
    logic [12:0] instr_pc;
`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0] mem [0:8191];
    int n_chk = 0;
    int n_fail = 0;
    int exp_stall = 0;

    typedef struct {
        logic [2:0]  op;
        logic [12:0] opd;
        logic        lng;
        logic [12:0] pc;
    } exp_t;
    exp_t sb[$];

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .memRead     (memRead),
        .addressMem  (addressMem),
        .memOut      (memOut),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .is_long     (is_long),
        .instr_pc    (instr_pc)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (memRead) memOut <= mem[addressMem];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [12:0] opd, input logic lng,
                        input logic [12:0] pc);
        exp_t e;
        e.op = op; e.opd = opd; e.lng = lng; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Entered while the DUT is in ISSUE0; leaves it in the next ISSUE0.
    task automatic run_instr(input int lat, input int stall, input int redir);
        exp_t e;
        int   n;
        logic [31:0] r;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("issue_rd", 32'(memRead), 32'd1);
        chk("issue_addr", 32'(addressMem), 32'(e.pc));
        instr_ready = (stall == 0);
        n = 0;
        while (!instr_valid && n < 12) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("operand", 32'(operand), 32'(e.opd));
        chk("is_long", 32'(is_long), 32'(e.lng));
        chk("instr_pc", 32'(instr_pc), 32'(e.pc));
        for (int s = 0; s < stall; s++) begin
            step();
            exp_stall++;
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_rd", 32'(memRead), 32'd0);
            chk("hold_opd", 32'(operand), 32'(e.opd));
        end
        instr_ready = 1'b1;
`ifdef IFETCH_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
        if (redir >= 0) begin
            r = 32'(redir);
            pc_load = 1'b1;
            pc_new  = r[12:0];
        end
        step();
        pc_load = 1'b0;
        if (redir >= 0) chk("redir_valid", 32'(instr_valid), 32'd0);
    endtask

    // Redirect 'phase' cycles after ISSUE0 of an instruction that is dropped.
    task automatic redirect_at(input int phase, input logic [12:0] target);
        chk("pre_rd", 32'(memRead), 32'd1);
        repeat (phase) step();
        pc_load = 1'b1;
        pc_new  = target;
        step();
        pc_load = 1'b0;
        chk("redir_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[0]       = 8'hF0;
        mem[1]       = 8'h03;
        mem[2]       = 8'hE7;
        mem[3]       = 8'hA5;
        mem[4]       = 8'h12;
        mem[37]      = 8'h27;
        mem[38]      = 8'hD0;
        mem[100]     = 8'h40;
        mem[101]     = 8'h11;
        mem[200]     = 8'h61;
        mem[201]     = 8'h55;
        mem[13'h1FFF] = 8'h15;

        repeat (2) step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_rd", 32'(memRead), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_is_long", 32'(is_long), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef IFETCH_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif

        push(3'd7, 13'h0010, 1'b0, 13'd0);
        push(3'd0, 13'd999, 1'b1, 13'd1);
        push(3'd5, 13'd5, 1'b0, 13'd3);
        reset = 1'b0;
        #1;
        run_instr(2, 0, -1);
        run_instr(4, 0, -1);
        run_instr(2, 5, -1);

        // Long instruction at 4 is abandoned in CAP0.
        redirect_at(1, 13'd37);
        push(3'd1, 13'd2000, 1'b1, 13'd37);
        run_instr(4, 0, 13'h1FFF);

        // Wrap: byte1 comes from address 0, then fetch resumes at 1.
        push(3'd0, 13'h15F0, 1'b1, 13'h1FFF);
        run_instr(4, 0, -1);
        push(3'd0, 13'd999, 1'b1, 13'd1);
        run_instr(4, 0, 200);

        // Redirect in ISSUE1: the byte from 201 must be ignored.
        redirect_at(2, 13'd100);
        push(3'd2, 13'h0011, 1'b1, 13'd100);
        run_instr(4, 0, -1);

        // Reset in CAP1 of the long instruction at 102.
        repeat (3) step();
        chk("cap1_rd", 32'(memRead), 32'd0);
        chk("cap1_valid", 32'(instr_valid), 32'd0);
        reset = 1'b1;
        step();
        exp_stall = 0;
        chk("rst2_valid", 32'(instr_valid), 32'd0);
        chk("rst2_rd", 32'(memRead), 32'd0);
        chk("rst2_addr", 32'(addressMem), 32'd0);
        chk("rst2_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst2_is_long", 32'(is_long), 32'd0);
`ifdef IFETCH_STALL_CNT_EN
        chk("rst2_stall", 32'(stall_cnt), 32'd0);
`endif
        reset = 1'b0;
        #1;
        push(3'd7, 13'h0010, 1'b0, 13'd0);
        run_instr(2, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
